// File: rtl/sic_dispatch_arbiter_pkg.sv
// ============================================================================
// Module : sic_dispatch_arbiter_pkg
// Brief  : Shared SIC-side types: issued packet, redirect record, id ordering.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sic_dispatch_arbiter_pkg;

    localparam int c_id_width = 8;

    typedef struct packed {
        logic [c_id_width-1:0] issue_id;
        logic [31:0]           pc;
        logic [31:0]           instr;
    } sic_packet_t;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           pc;
        logic [c_id_width-1:0] id;
    } redir_t;

    // Wrap-safe age compare: a is older than b when (a-b) has its MSB set.
    function automatic logic id_older(input logic [c_id_width-1:0] a,
                                      input logic [c_id_width-1:0] b);
        logic [c_id_width-1:0] diff;
        diff = a - b;
        return diff[c_id_width-1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sic_rr_pick.sv
// ============================================================================
// Module : sic_rr_pick
// Brief  : Round-robin picker: rotate by ptr, priority-encode, unrotate.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sic_rr_pick #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          any
);

    logic [N-1:0]  w_rot;
    logic [PW-1:0] w_off;
    logic [PW:0]   w_sum;

    always_comb begin
        w_rot = N'({req, req} >> ptr);
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = PW'(k);
            end
        end
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= (PW+1)'(N)) begin
            w_sum = w_sum - (PW+1)'(N);
        end
        grant = w_sum[PW-1:0];
        any   = |req;
    end

endmodule

`default_nettype wire

// File: rtl/sic_dispatch_arbiter.sv
// ============================================================================
// Module : sic_dispatch_arbiter
// Brief  : 2-entry issue buffer, round-robin dispatch to SICs, oldest-first
//          redirect merge with id-based flush of buffered packets.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sic_dispatch_arbiter
    import sic_dispatch_arbiter_pkg::*;
#(
    parameter int NUM_SIC  = 4,
    parameter int ID_WIDTH = 8,
    parameter int FIFO_DEP = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  sic_packet_t                  in_pkt,
    input  logic [NUM_SIC-1:0]           sic_req_instr,
    output logic [NUM_SIC-1:0]           sic_pkt_valid,
    output sic_packet_t                  sic_pkt,
    input  logic [NUM_SIC-1:0]           sic_redir_valid,
    input  logic [NUM_SIC*32-1:0]        sic_redir_pc,
    input  logic [NUM_SIC*ID_WIDTH-1:0]  sic_redir_id,
    output logic                         redir_valid,
    output logic [31:0]                  redir_pc,
    output logic [ID_WIDTH-1:0]          redir_issue_id
);

    localparam int PW = $clog2(NUM_SIC);

    if (FIFO_DEP != 2) begin : g_bad_fifo_dep
        $error("sic_dispatch_arbiter: FIFO_DEP must be 2");
    end
    if (ID_WIDTH != c_id_width) begin : g_bad_id_width
        $error("sic_dispatch_arbiter: ID_WIDTH must match package id width");
    end
    if (NUM_SIC < 2 || NUM_SIC > 8) begin : g_bad_num_sic
        $error("sic_dispatch_arbiter: NUM_SIC must be 2..8");
    end

    sic_packet_t          r_fifo [2];
    logic [1:0]           r_count;
    logic [PW-1:0]        r_rr_ptr;
    logic [NUM_SIC-1:0]   r_mask;
    logic                 r_redir_valid;
    logic [31:0]          r_redir_pc;
    logic [ID_WIDTH-1:0]  r_redir_id;

    sic_packet_t          w_fifo_nxt [2];
    logic [1:0]           w_count_nxt;
    logic [1:0]           w_slot;
    logic                 w_keep0;
    logic                 w_keep1;
    logic [NUM_SIC-1:0]   w_elig;
    logic [PW-1:0]        w_grant;
    logic [PW-1:0]        w_rr_nxt;
    logic [NUM_SIC-1:0]   w_grant_oh;
    logic                 w_any;
    logic                 w_fire;
    logic                 w_push;
    redir_t               w_cand [NUM_SIC];
    redir_t               w_best;

    assign in_ready = !rst && (r_count != 2'd2) && !r_redir_valid;
    assign w_push   = in_valid && in_ready;

    // The one-cycle mask hides a just-granted SIC whose req_instr is still high.
    assign w_elig = sic_req_instr & ~r_mask;

    sic_rr_pick #(.N(NUM_SIC)) u_pick (
        .req   (w_elig),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .any   (w_any)
    );

    assign w_fire     = !rst && (r_count != 2'd0) && w_any && !r_redir_valid;
    assign w_grant_oh = NUM_SIC'(1) << w_grant;
    assign w_rr_nxt   = (w_grant == PW'(NUM_SIC - 1)) ? '0 : w_grant + PW'(1);

    assign sic_pkt_valid = w_fire ? w_grant_oh : '0;
    assign sic_pkt       = w_fire ? r_fifo[0] : '0;

    always_comb begin
        w_fifo_nxt[0] = r_fifo[0];
        w_fifo_nxt[1] = r_fifo[1];
        w_count_nxt   = r_count;
        w_slot        = r_count - {1'b0, w_fire};
        w_keep0       = (r_count != 2'd0) && !id_older(r_redir_id, r_fifo[0].issue_id);
        w_keep1       = (r_count == 2'd2) && !id_older(r_redir_id, r_fifo[1].issue_id);
        if (r_redir_valid) begin
            // Flush younger entries; survivors slide down in order.
            if (!w_keep0) begin
                w_fifo_nxt[0] = r_fifo[1];
            end
            w_count_nxt = {1'b0, w_keep0} + {1'b0, w_keep1};
        end else begin
            if (w_fire) begin
                w_fifo_nxt[0] = r_fifo[1];
            end
            if (w_push) begin
                if (w_slot == 2'd0) begin
                    w_fifo_nxt[0] = in_pkt;
                end else begin
                    w_fifo_nxt[1] = in_pkt;
                end
            end
            w_count_nxt = w_slot + {1'b0, w_push};
        end
    end

    for (genvar gi = 0; gi < NUM_SIC; gi++) begin : g_redir_cand
        assign w_cand[gi] = '{valid: sic_redir_valid[gi],
                              pc:    sic_redir_pc[gi*32 +: 32],
                              id:    sic_redir_id[gi*ID_WIDTH +: ID_WIDTH]};
    end

    // Strictly-older replacement keeps the lowest index on equal ids.
    always_comb begin
        w_best = '0;
        for (int i = 0; i < NUM_SIC; i++) begin
            if (w_cand[i].valid && (!w_best.valid || id_older(w_cand[i].id, w_best.id))) begin
                w_best = w_cand[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo[0]     <= '0;
            r_fifo[1]     <= '0;
            r_count       <= 2'd0;
            r_rr_ptr      <= '0;
            r_mask        <= '0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
            r_redir_id    <= '0;
        end else begin
            r_fifo[0]     <= w_fifo_nxt[0];
            r_fifo[1]     <= w_fifo_nxt[1];
            r_count       <= w_count_nxt;
            r_redir_valid <= w_best.valid;
            if (w_fire) begin
                r_rr_ptr <= w_rr_nxt;
                r_mask   <= w_grant_oh;
            end else begin
                r_mask   <= '0;
            end
            if (w_best.valid) begin
                r_redir_pc <= w_best.pc;
                r_redir_id <= w_best.id;
            end
        end
    end

    assign redir_valid    = r_redir_valid;
    assign redir_pc       = r_redir_pc;
    assign redir_issue_id = r_redir_id;

endmodule

`default_nettype wire

// File: tb/tb_sic_dispatch_arbiter.sv
// ============================================================================
// Module : tb_sic_dispatch_arbiter
// Brief  : Directed vector table plus randomized run against a queue model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sic_dispatch_arbiter;
    import sic_dispatch_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    sic_packet_t   in_pkt = '0;
    logic [N-1:0]  sic_req_instr = '0;
    logic [N-1:0]  sic_pkt_valid;
    sic_packet_t   sic_pkt;
    logic [N-1:0]  sic_redir_valid = '0;
    logic [N*32-1:0] sic_redir_pc = '0;
    logic [N*IW-1:0] sic_redir_id = '0;
    logic          redir_valid;
    logic [31:0]   redir_pc;
    logic [IW-1:0] redir_issue_id;

    always #5 clk = ~clk;

    sic_dispatch_arbiter #(.NUM_SIC(N), .ID_WIDTH(IW), .FIFO_DEP(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pkt          (in_pkt),
        .sic_req_instr   (sic_req_instr),
        .sic_pkt_valid   (sic_pkt_valid),
        .sic_pkt         (sic_pkt),
        .sic_redir_valid (sic_redir_valid),
        .sic_redir_pc    (sic_redir_pc),
        .sic_redir_id    (sic_redir_id),
        .redir_valid     (redir_valid),
        .redir_pc        (redir_pc),
        .redir_issue_id  (redir_issue_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic sic_packet_t mk(input logic [7:0] id);
        sic_packet_t p;
        p.issue_id = id;
        p.pc       = {22'h0, id, 2'b00};
        p.instr    = {id, ~id, id, 8'h5A};
        return p;
    endfunction

    // Behavioural model: packet queue, round-robin index, one-cycle mask
    sic_packet_t  mq[$];
    int           m_rr   = 0;
    logic [N-1:0] m_mask = '0;
    logic         m_rv   = 1'b0;
    logic [31:0]  m_rpc  = '0;
    logic [7:0]   m_rid  = '0;

    function automatic bit older(input logic [7:0] a, input logic [7:0] b);
        return ((int'(a) - int'(b) + 256) % 256) >= 128;
    endfunction

    function automatic int pick(input logic [N-1:0] elig);
        for (int k = 0; k < N; k++) begin
            if (elig[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_cmp();
        int g;
        bit fire;
        bit rdy;
        g    = pick(sic_req_instr & ~m_mask);
        fire = !rst && (mq.size() > 0) && (g >= 0) && !m_rv;
        rdy  = !rst && (mq.size() < 2) && !m_rv;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("sic_pkt_valid", 32'(sic_pkt_valid), fire ? (32'd1 << g) : 32'd0);
        if (fire) begin
            chk("sic_pkt.issue_id", 32'(sic_pkt.issue_id), 32'(mq[0].issue_id));
            chk("sic_pkt.pc", sic_pkt.pc, mq[0].pc);
            chk("sic_pkt.instr", sic_pkt.instr, mq[0].instr);
        end
        chk("redir_valid", 32'(redir_valid), 32'(m_rv));
        chk("redir_pc", redir_pc, m_rpc);
        chk("redir_issue_id", 32'(redir_issue_id), 32'(m_rid));
    endtask

    task automatic model_upd();
        int  g;
        bit  fire;
        bit  push;
        int  best;
        g    = pick(sic_req_instr & ~m_mask);
        fire = !rst && (mq.size() > 0) && (g >= 0) && !m_rv;
        push = in_valid && !rst && (mq.size() < 2) && !m_rv;
        best = -1;
        for (int i = 0; i < N; i++) begin
            if (sic_redir_valid[i] &&
                (best < 0 || older(sic_redir_id[i*IW +: IW], sic_redir_id[best*IW +: IW])))
                best = i;
        end
        if (rst) begin
            mq.delete();
            m_rr = 0; m_mask = '0; m_rv = 1'b0; m_rpc = '0; m_rid = '0;
        end else begin
            if (m_rv) begin
                sic_packet_t keep[$];
                foreach (mq[j]) if (!older(m_rid, mq[j].issue_id)) keep.push_back(mq[j]);
                mq = keep;
                m_mask = '0;
            end else begin
                if (fire) begin
                    void'(mq.pop_front());
                    m_rr   = (g + 1) % N;
                    m_mask = N'(1) << g;
                end else begin
                    m_mask = '0;
                end
                if (push) mq.push_back(in_pkt);
            end
            m_rv = (best >= 0);
            if (best >= 0) begin
                m_rpc = sic_redir_pc[best*32 +: 32];
                m_rid = sic_redir_id[best*IW +: IW];
            end
        end
    endtask

    task automatic drive(input bit r, input bit iv, input logic [7:0] id,
                         input logic [N-1:0] req, input logic [N-1:0] rv,
                         input logic [N*IW-1:0] rid, input logic [N*32-1:0] rpc);
        @(negedge clk);
        rst = r; in_valid = iv; in_pkt = mk(id); sic_req_instr = req;
        sic_redir_valid = rv; sic_redir_id = rid; sic_redir_pc = rpc;
        #4;
    endtask

    task automatic close_cycle();
        @(posedge clk);
        model_upd();
    endtask

    typedef struct {
        bit            rst;
        bit            iv;
        logic [7:0]    id;
        logic [N-1:0]  req;
        logic [N-1:0]  rv;
        logic [N*IW-1:0] rid;
        logic [N*32-1:0] rpc;
        bit            chk_en;
        logic          e_rdy;
        logic [N-1:0]  e_pv;
        logic [7:0]    e_pid;
        logic          e_rdv;
        logic [31:0]   e_rpc;
        logic [7:0]    e_rid;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit iv, input logic [7:0] id, input logic [N-1:0] req,
                       input logic [N-1:0] rv, input logic [N*IW-1:0] rid, input logic [N*32-1:0] rpc,
                       input bit c, input logic e_rdy, input logic [N-1:0] e_pv, input logic [7:0] e_pid,
                       input logic e_rdv, input logic [31:0] e_rpc, input logic [7:0] e_rid);
        vec_t v;
        v = '{r, iv, id, req, rv, rid, rpc, c, e_rdy, e_pv, e_pid, e_rdv, e_rpc, e_rid};
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*IW-1:0] rid;
        logic [N*32-1:0] rpc;
        logic [N-1:0]    rv;
        int              ctr;

        //   rst iv id    req    rv     rid                          rpc                                          chk rdy pv     pid    rdv pc          id
        add(1, 0, 8'h00, 4'h0, 4'h0, '0, '0, 0, 0, 4'h0, 8'h00, 0, 32'h0, 8'h00);
        add(1, 0, 8'h00, 4'h0, 4'h0, '0, '0, 1, 0, 4'h0, 8'h00, 0, 32'h0, 8'h00);
        // three packets to idle SICs, round-robin from 0
        add(0, 1, 8'h05, 4'hF, 4'h0, '0, '0, 1, 1, 4'h0, 8'h00, 0, 32'h0, 8'h00);
        add(0, 1, 8'h06, 4'hF, 4'h0, '0, '0, 1, 1, 4'h1, 8'h05, 0, 32'h0, 8'h00);
        add(0, 1, 8'h07, 4'hF, 4'h0, '0, '0, 1, 1, 4'h2, 8'h06, 0, 32'h0, 8'h00);
        add(0, 0, 8'h00, 4'hF, 4'h0, '0, '0, 1, 1, 4'h4, 8'h07, 0, 32'h0, 8'h00);
        // fill with no requester, then SIC3 takes id1, masked SIC3 skipped next
        add(0, 1, 8'h01, 4'h0, 4'h0, '0, '0, 1, 1, 4'h0, 8'h00, 0, 32'h0, 8'h00);
        add(0, 1, 8'h02, 4'h0, 4'h0, '0, '0, 1, 1, 4'h0, 8'h00, 0, 32'h0, 8'h00);
        add(0, 1, 8'h03, 4'h0, 4'h0, '0, '0, 1, 0, 4'h0, 8'h00, 0, 32'h0, 8'h00);
        add(0, 0, 8'h00, 4'h8, 4'h0, '0, '0, 1, 0, 4'h8, 8'h01, 0, 32'h0, 8'h00);
        add(0, 0, 8'h00, 4'h9, 4'h0, '0, '0, 1, 1, 4'h1, 8'h02, 0, 32'h0, 8'h00);
        // SIC1 id 0x10 vs SIC2 id 0x0E
        add(0, 0, 8'h00, 4'h0, 4'h6, {8'h00, 8'h0E, 8'h10, 8'h00},
            {32'h0, 32'h800, 32'h400, 32'h0}, 1, 1, 4'h0, 8'h00, 0, 32'h0, 8'h00);
        add(0, 0, 8'h00, 4'h0, 4'h0, '0, '0, 1, 0, 4'h0, 8'h00, 1, 32'h800, 8'h0E);
        // wrap: 0xFE older than 0x01
        add(0, 0, 8'h00, 4'h0, 4'h9, {8'h01, 8'h00, 8'h00, 8'hFE},
            {32'h2000, 32'h0, 32'h0, 32'h1000}, 1, 1, 4'h0, 8'h00, 0, 32'h800, 8'h0E);
        add(0, 0, 8'h00, 4'h0, 4'h0, '0, '0, 1, 0, 4'h0, 8'h00, 1, 32'h1000, 8'hFE);
        // flush: 0x0D kept, 0x0F dropped by redirect 0x0E
        add(0, 1, 8'h0D, 4'h0, 4'h0, '0, '0, 1, 1, 4'h0, 8'h00, 0, 32'h1000, 8'hFE);
        add(0, 1, 8'h0F, 4'h0, 4'h2, {8'h00, 8'h00, 8'h0E, 8'h00},
            {32'h0, 32'h0, 32'h3000, 32'h0}, 1, 1, 4'h0, 8'h00, 0, 32'h1000, 8'hFE);
        add(0, 1, 8'h20, 4'hF, 4'h0, '0, '0, 1, 0, 4'h0, 8'h00, 1, 32'h3000, 8'h0E);
        add(0, 0, 8'h00, 4'hF, 4'h0, '0, '0, 1, 1, 4'h2, 8'h0D, 0, 32'h3000, 8'h0E);
        // reset with full FIFO and a redirect pulse in flight
        add(0, 1, 8'h30, 4'h0, 4'h0, '0, '0, 1, 1, 4'h0, 8'h00, 0, 32'h3000, 8'h0E);
        add(0, 1, 8'h31, 4'h0, 4'h0, '0, '0, 1, 1, 4'h0, 8'h00, 0, 32'h3000, 8'h0E);
        add(1, 1, 8'h32, 4'hF, 4'h1, {8'h00, 8'h00, 8'h00, 8'h40},
            {32'h0, 32'h0, 32'h0, 32'h5000}, 1, 0, 4'h0, 8'h00, 0, 32'h3000, 8'h0E);
        add(0, 0, 8'h00, 4'hF, 4'h0, '0, '0, 1, 1, 4'h0, 8'h00, 0, 32'h0, 8'h00);
        add(0, 0, 8'h00, 4'hF, 4'h0, '0, '0, 1, 1, 4'h0, 8'h00, 0, 32'h0, 8'h00);
        add(0, 1, 8'h33, 4'hF, 4'h0, '0, '0, 1, 1, 4'h0, 8'h00, 0, 32'h0, 8'h00);
        add(0, 0, 8'h00, 4'hF, 4'h0, '0, '0, 1, 1, 4'h1, 8'h33, 0, 32'h0, 8'h00);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].id, vecs[i].req, vecs[i].rv, vecs[i].rid, vecs[i].rpc);
            if (vecs[i].chk_en) begin
                chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
                chk($sformatf("v%0d sic_pkt_valid", i), 32'(sic_pkt_valid), 32'(vecs[i].e_pv));
                if (vecs[i].e_pv != '0)
                    chk($sformatf("v%0d sic_pkt_id", i), 32'(sic_pkt.issue_id), 32'(vecs[i].e_pid));
                chk($sformatf("v%0d redir_valid", i), 32'(redir_valid), 32'(vecs[i].e_rdv));
                chk($sformatf("v%0d redir_pc", i), redir_pc, vecs[i].e_rpc);
                chk($sformatf("v%0d redir_issue_id", i), 32'(redir_issue_id), 32'(vecs[i].e_rid));
            end
            close_cycle();
        end

        // Randomized traffic with ids advancing and redirects near the head
        ctr = 8'h40;
        for (int c = 0; c < 600; c++) begin
            rv = '0;
            for (int i = 0; i < N; i++) begin
                rv[i]            = ($urandom_range(0, 9) == 0);
                rid[i*IW +: IW]  = 8'(ctr - int'($urandom_range(0, 6)));
                rpc[i*32 +: 32]  = $urandom;
            end
            drive((c == 0) || ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  8'(ctr), N'($urandom), rv, rid, rpc);
            model_cmp();
            close_cycle();
            ctr++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
